sz_quant_bin: RTL and testbench
===============================

// Module: sz_quant_bin
// PURPOSE
//  Linear-quantization binning stage of the SZ first-stage pipeline, directly upstream of the
//  fixed-to-float converter. Takes the signed integer prediction error q = round(err/(2*eb)),
//  maps it to an SZ quantization code and emits the clamped fixed value fed to the converter.
//  Out-of-range points are flagged unpredictable and counted. Valid/ready on both sides, with
//  an internal skid buffer so the converter side can stall.
// PARAMETERS
//  DATA_W   32     width of in_q and out_fix (signed two's complement)
//  RADIUS   32768  quantization interval radius; legal |q| < RADIUS
//  CODE_W   16     code width; 2**CODE_W >= 2*RADIUS is required (elaboration error otherwise)
//  CNT_W    32     width of point and unpredictable counters
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       reset, synchronous, active-high
//  in_valid     in   1       in_q/in_last valid
//  in_ready     out  1       stage can accept this cycle
//  in_q         in   DATA_W  signed rounded prediction error
//  in_last      in   1       last point of a data block
//  out_valid    out  1       output fields valid
//  out_ready    in   1       downstream accepts this cycle
//  out_code     out  CODE_W  0 = unpredictable, else q+RADIUS (1..2*RADIUS-1)
//  out_fix      out  DATA_W  q if predictable, else 0 (goes to the fixed-to-float converter)
//  out_unpred   out  1       point unpredictable
//  out_last     out  1       in_last carried through
//  stats_valid  out  1       one-cycle pulse, block statistics valid
//  stats_pts    out  CNT_W   points emitted in finished block
//  stats_unpred out  CNT_W   unpredictable points in finished block
// BEHAVIOUR
//  Reset: one clock and one synchronous active-high reset rst; at rst=1 all valids, stats_valid,
//   counters, and data/stat outputs go to 0; in_ready=0 during rst, then 1 the cycle after.
//   Reset mid-operation drops in-flight points without emitting them.
//  Classification: unpred = (q >= RADIUS) || (q <= -RADIUS), signed compare at DATA_W bits.
//   Predictable: out_code = q+RADIUS truncated to CODE_W (always fits); out_fix = q.
//   Unpredictable: out_code = 0, out_fix = 0, out_unpred = 1.
//  Pipeline: input handshake (in_valid&&in_ready) loads main register; result is visible
//   next cycle -> latency 1 with out_ready held 1; one point per cycle sustained.
//  Skid: if out_valid && !out_ready, all out_* stay stable. A point accepted that cycle goes
//   to the skid register; in_ready is then 0 (registered, no comb path from out_ready to
//   in_ready). When out_ready returns, the main register drains first, then the skid
//   register; order is strict FIFO. Capacity 2 points; in_ready = !skid_full.
//  Counters: pts/unpred accumulators update on output handshake (out_valid&&out_ready);
//   saturate at 2**CNT_W-1, no wrap.
//  Block end: output handshake with out_last=1 -> next cycle stats_valid=1 with totals
//   including the last point; accumulators restart from 0 the same cycle, so a point
//   handshaken in the cycle after the last point counts toward the next block.
//   stats_* hold value until the next pulse.
//  Simultaneous in/out handshake with main full and skid empty: main reloads, no skid use.
// STRUCTURE
//  Package sz_pkg: RADIUS, CODE_W, DATA_W defaults; typedef of the {code,fix,unpred,last}
//   payload struct; function sz_classify(q) returning the payload.
//  Sub-module sz_skid_buf (payload-width parameterized 2-entry valid/ready register slice);
//   classification and counters stay in sz_quant_bin.
// TESTING
//  T1 reset: rst=1 for 3 cycles with in_valid=1 -> out_valid=0, stats_valid=0, counters 0.
//  T2 mapping, out_ready=1: q=0,5,-32767,32767,32768,-32768 -> codes 32768,32773,1,65535,0,0;
//   out_fix 0,5,-32767,32767,0,0; out_unpred only on last two; each output 1 cycle after input.
//  T3 backpressure: stream q=1..10, out_ready=0 for cycles 3-7 -> in_ready low after 2
//   buffered points, no loss/dup, outputs in order 1..10, stable while stalled.
//  T4 block stats: 8 points with 3 out-of-range, in_last on 8th -> stats_valid 1 cycle
//   later, stats_pts=8, stats_unpred=3; next block of 2 predictable -> stats 2/0.
//  T5 back-to-back blocks: last of block A then first of B on next cycle -> A stats exclude
//   B point; B totals correct.
//  T6 mid-stream reset with skid full -> buffered points never appear; first post-reset
//   point q=7 emits code 32775 with latency 1.

Source files
------------

// File: rtl/sz_pkg.sv
// sz_pkg: shared widths, payload layout and classification for the SZ quantization binning stage.
package sz_pkg;
    localparam int SZ_DATA_W = 32;
    localparam int SZ_RADIUS = 32768;
    localparam int SZ_CODE_W = 16;
    localparam int SZ_CNT_W  = 32;

    typedef struct packed {
        logic [SZ_CODE_W-1:0]        code;
        logic signed [SZ_DATA_W-1:0] fix;
        logic                        unpred;
        logic                        last;
    } sz_payload_t;

    function automatic sz_payload_t sz_classify(input logic signed [SZ_DATA_W-1:0] q, input logic last);
        sz_payload_t p;
        logic signed [SZ_DATA_W-1:0] sum;
        sum      = q + SZ_DATA_W'(SZ_RADIUS);
        p.unpred = (q >= SZ_DATA_W'(SZ_RADIUS)) || (q <= SZ_DATA_W'(-SZ_RADIUS));
        p.code   = p.unpred ? '0 : sum[SZ_CODE_W-1:0];
        p.fix    = p.unpred ? '0 : q;
        p.last   = last;
        return p;
    endfunction
endpackage

// File: rtl/sz_skid_buf.sv
// sz_skid_buf: 2-entry valid/ready register slice; in_ready is registered, no comb path from out_ready.
module sz_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         main_v, skid_v, rdy, in_hs, stall, skid_n;
    logic [W-1:0] main_d, skid_d;

    assign in_hs     = in_valid && rdy;
    assign stall     = main_v && !out_ready;
    assign skid_n    = stall && (skid_v || in_hs);
    assign in_ready  = rdy;
    assign out_valid = main_v;
    assign out_data  = main_d;

    // the skid entry always drains into main before any new input is taken
    always_ff @(posedge clk) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy    <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            rdy    <= !skid_n;
            skid_v <= skid_n;
            if (!stall) main_v <= skid_v || in_hs;
            if (!stall && (skid_v || in_hs)) main_d <= skid_v ? skid_d : in_data;
            if (stall && in_hs) skid_d <= in_data;
        end
    end
endmodule

// File: rtl/sz_quant_bin.sv
// sz_quant_bin: maps rounded prediction error q to an SZ quantization code and clamped fixed value,
// with per-block point / unpredictable statistics.
module sz_quant_bin import sz_pkg::*; #(
    parameter int DATA_W = SZ_DATA_W,
    parameter int RADIUS = SZ_RADIUS,
    parameter int CODE_W = SZ_CODE_W,
    parameter int CNT_W  = SZ_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_q,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CODE_W-1:0]        out_code,
    output logic signed [DATA_W-1:0] out_fix,
    output logic                     out_unpred,
    output logic                     out_last,
    output logic                     stats_valid,
    output logic [CNT_W-1:0]         stats_pts,
    output logic [CNT_W-1:0]         stats_unpred
);
    if ((longint'(1) << CODE_W) < 2 * longint'(RADIUS)) begin : g_code_w
        $error("CODE_W too narrow to hold 2*RADIUS codes");
    end
    if (DATA_W != SZ_DATA_W || RADIUS != SZ_RADIUS || CODE_W != SZ_CODE_W) begin : g_layout
        $error("payload layout is fixed by sz_pkg widths");
    end

    sz_payload_t      in_p, out_p;
    logic             out_hs;
    logic [CNT_W-1:0] pts, unp, pts_inc, unp_inc;

    assign in_p = sz_classify(in_q, in_last);

    sz_skid_buf #(.W($bits(sz_payload_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_p)
    );

    assign out_code   = out_p.code;
    assign out_fix    = out_p.fix;
    assign out_unpred = out_p.unpred;
    assign out_last   = out_p.last;

    always_comb begin
        out_hs  = out_valid && out_ready;
        pts_inc = &pts ? pts : pts + CNT_W'(1);
        unp_inc = (out_p.unpred && !(&unp)) ? unp + CNT_W'(1) : unp;
    end

    // totals include the last point; accumulators restart on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            pts          <= '0;
            unp          <= '0;
            stats_valid  <= 1'b0;
            stats_pts    <= '0;
            stats_unpred <= '0;
        end else begin
            stats_valid <= out_hs && out_p.last;
            if (out_hs && out_p.last) begin
                stats_pts    <= pts_inc;
                stats_unpred <= unp_inc;
            end
            if (out_hs) begin
                pts <= out_p.last ? '0 : pts_inc;
                unp <= out_p.last ? '0 : unp_inc;
            end
        end
    end
endmodule

// File: tb/tb_sz_quant_bin.sv
// tb_sz_quant_bin: randomized and directed checks of sz_quant_bin against a queue-based reference model.
module tb_sz_quant_bin;
    logic               clk = 1'b0, rst = 1'b1;
    logic               in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic signed [31:0] in_q = '0;
    logic               in_ready, out_valid, out_unpred, out_last, stats_valid;
    logic [15:0]        out_code;
    logic signed [31:0] out_fix;
    logic [31:0]        stats_pts, stats_unpred;

    sz_quant_bin dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code), .out_fix(out_fix),
        .out_unpred(out_unpred), .out_last(out_last), .stats_valid(stats_valid),
        .stats_pts(stats_pts), .stats_unpred(stats_unpred)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] code; logic signed [31:0] fix; logic unpred; logic last; int cyc; } pt_t;
    typedef struct { logic [31:0] pts; logic [31:0] unp; int cyc; } st_t;

    int  n_cmp = 0, n_bad = 0, cyc = 0;
    pt_t exp_q[$], obs_q[$];
    st_t st_q[$], est_q[$];

    function automatic pt_t model(int q, bit last, int c);
        pt_t p;
        p.unpred = (q >= 32768) || (q <= -32768);
        p.code   = p.unpred ? 16'd0 : 16'(q + 32768);
        p.fix    = p.unpred ? 32'sd0 : 32'(q);
        p.last   = last;
        p.cyc    = c;
        return p;
    endfunction

    function automatic void model_stats();
        int p = 0, u = 0;
        est_q.delete();
        foreach (exp_q[i]) begin
            p++;
            u += int'(exp_q[i].unpred);
            if (exp_q[i].last) begin
                est_q.push_back('{32'(p), 32'(u), 0});
                p = 0;
                u = 0;
            end
        end
    endfunction

    task automatic tick();
        if (in_valid && in_ready) exp_q.push_back(model(int'(in_q), in_last, cyc));
        if (out_valid && out_ready) obs_q.push_back('{out_code, out_fix, out_unpred, out_last, cyc});
        if (stats_valid) st_q.push_back('{stats_pts, stats_unpred, cyc});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear();
        in_valid = 0; in_last = 0; out_ready = 1; rst = 1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        @(posedge clk); #1;
        exp_q.delete(); obs_q.delete(); st_q.delete();
    endtask

    task automatic drain();
        in_valid = 0; in_last = 0; out_ready = 1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1; in_valid = 1; in_q = 5; out_ready = 1;
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
            n_cmp++; if (stats_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stats_valid: got %b want 0", stats_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
            n_cmp++; if (stats_pts !== 0 || stats_unpred !== 0 || out_code !== 0 || out_fix !== 0) begin
                n_bad++; $display("FAIL rst_data: got pts=%0d unp=%0d code=%0d fix=%0d want all 0", stats_pts, stats_unpred, out_code, out_fix); end
        end
        in_valid = 0; rst = 0;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_no_emit: got %b want 0", out_valid); end
    endtask

    task automatic test_mapping();
        int qs[6]    = '{0, 5, -32767, 32767, 32768, -32768};
        int codes[6] = '{32768, 32773, 1, 65535, 0, 0};
        int fixes[6] = '{0, 5, -32767, 32767, 0, 0};
        clear();
        for (int i = 0; i < 6; i++) begin in_valid = 1; in_q = qs[i]; tick(); end
        drain();
        n_cmp++; if (obs_q.size() != 6) begin n_bad++; $display("FAIL map_count: got %0d want 6", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 6; i++) begin
            n_cmp++; if (obs_q[i].code !== 16'(codes[i]) || obs_q[i].fix !== 32'(fixes[i]) || obs_q[i].unpred !== (i >= 4)) begin
                n_bad++; $display("FAIL map_q%0d: got code=%0d fix=%0d unp=%0b want code=%0d fix=%0d unp=%0b",
                    qs[i], obs_q[i].code, obs_q[i].fix, obs_q[i].unpred, codes[i], fixes[i], i >= 4); end
            n_cmp++; if (i < exp_q.size() && obs_q[i].cyc - exp_q[i].cyc != 1) begin
                n_bad++; $display("FAIL map_latency%0d: got %0d want 1", i, obs_q[i].cyc - exp_q[i].cyc); end
        end
    endtask

    task automatic test_backpressure();
        int          sent = 0;
        logic [15:0] sc;
        logic [31:0] sf;
        bit          low = 0, hold;
        clear();
        for (int k = 0; k < 40 && sent < 10; k++) begin
            out_ready = !(k >= 3 && k <= 7); in_valid = 1; in_q = sent + 1; in_last = 0;
            if (!in_ready) low = 1;
            hold = out_valid && !out_ready; sc = out_code; sf = out_fix;
            if (in_ready) sent++;
            tick();
            if (hold) begin
                n_cmp++; if (!out_valid || out_code !== sc || out_fix !== sf) begin
                    n_bad++; $display("FAIL bp_stable: got v=%b fix=%0d want v=1 fix=%0d", out_valid, out_fix, sf); end
            end
        end
        drain();
        n_cmp++; if (!low) begin n_bad++; $display("FAIL bp_in_ready_low: got never-low want low"); end
        n_cmp++; if (obs_q.size() != 10) begin n_bad++; $display("FAIL bp_count: got %0d want 10", obs_q.size()); end
        for (int i = 0; i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i].fix !== 32'(i + 1) || obs_q[i].code !== 16'(32769 + i)) begin
                n_bad++; $display("FAIL bp_order%0d: got fix=%0d code=%0d want fix=%0d code=%0d", i, obs_q[i].fix, obs_q[i].code, i + 1, 32769 + i); end
        end
    endtask

    task automatic test_block_stats();
        int qs[10] = '{1, 40000, -2, -50000, 3, 32768, 4, 5, 10, -10};
        int lc = 0;
        clear();
        for (int i = 0; i < 10; i++) begin in_valid = 1; in_q = qs[i]; in_last = (i == 7 || i == 9); tick(); end
        drain();
        model_stats();
        n_cmp++; if (st_q.size() != 2 || est_q.size() != 2) begin n_bad++; $display("FAIL blk_pulses: got %0d want %0d", st_q.size(), est_q.size()); end
        for (int j = 0; j < st_q.size() && j < est_q.size(); j++) begin
            n_cmp++; if (st_q[j].pts !== est_q[j].pts || st_q[j].unp !== est_q[j].unp) begin
                n_bad++; $display("FAIL blk_stats%0d: got %0d/%0d want %0d/%0d", j, st_q[j].pts, st_q[j].unp, est_q[j].pts, est_q[j].unp); end
        end
        foreach (obs_q[i]) if (obs_q[i].last) begin
            if (lc < st_q.size()) begin
                n_cmp++; if (st_q[lc].cyc != obs_q[i].cyc + 1) begin
                    n_bad++; $display("FAIL blk_timing%0d: got %0d want %0d", lc, st_q[lc].cyc, obs_q[i].cyc + 1); end
            end
            lc++;
        end
        n_cmp++; if (stats_valid !== 1'b0 || stats_pts !== 32'd2 || stats_unpred !== 32'd0) begin
            n_bad++; $display("FAIL blk_hold: got v=%b %0d/%0d want v=0 2/0", stats_valid, stats_pts, stats_unpred); end
    endtask

    task automatic test_back_to_back();
        int qs[5] = '{100, -40000, 200, 7, 8};
        clear();
        for (int i = 0; i < 5; i++) begin in_valid = 1; in_q = qs[i]; in_last = (i == 2 || i == 4); tick(); end
        drain();
        model_stats();
        n_cmp++; if (st_q.size() != est_q.size()) begin n_bad++; $display("FAIL b2b_pulses: got %0d want %0d", st_q.size(), est_q.size()); end
        for (int j = 0; j < st_q.size() && j < est_q.size(); j++) begin
            n_cmp++; if (st_q[j].pts !== est_q[j].pts || st_q[j].unp !== est_q[j].unp) begin
                n_bad++; $display("FAIL b2b_stats%0d: got %0d/%0d want %0d/%0d", j, st_q[j].pts, st_q[j].unp, est_q[j].pts, est_q[j].unp); end
        end
    endtask

    task automatic test_random();
        int          bnd[6] = '{32767, -32767, 32768, -32768, 32766, -32766};
        int          r, q;
        logic [15:0] sc;
        logic [31:0] sf;
        bit          hold;
        clear();
        for (int k = 0; k < 400; k++) begin
            r = int'($urandom_range(0, 5));
            q = (r == 0) ? int'($urandom_range(0, 200)) - 100 :
                (r == 1) ? bnd[$urandom_range(0, 5)] :
                (r == 2) ? int'($urandom) : int'($urandom_range(0, 65534)) - 32767;
            in_valid = ($urandom_range(0, 3) != 0); in_q = q; in_last = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            hold = out_valid && !out_ready; sc = out_code; sf = out_fix;
            tick();
            if (hold) begin
                n_cmp++; if (!out_valid || out_code !== sc || out_fix !== sf) begin
                    n_bad++; $display("FAIL rnd_stable: got v=%b fix=%0d want v=1 fix=%0d", out_valid, out_fix, sf); end
            end
        end
        drain();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_cmp++; if (obs_q[i].code !== exp_q[i].code || obs_q[i].fix !== exp_q[i].fix ||
                         obs_q[i].unpred !== exp_q[i].unpred || obs_q[i].last !== exp_q[i].last) begin
                n_bad++; $display("FAIL rnd_pt%0d: got code=%0d fix=%0d unp=%0b last=%0b want code=%0d fix=%0d unp=%0b last=%0b", i,
                    obs_q[i].code, obs_q[i].fix, obs_q[i].unpred, obs_q[i].last, exp_q[i].code, exp_q[i].fix, exp_q[i].unpred, exp_q[i].last); end
        end
        model_stats();
        n_cmp++; if (st_q.size() != est_q.size()) begin n_bad++; $display("FAIL rnd_pulses: got %0d want %0d", st_q.size(), est_q.size()); end
        for (int j = 0; j < st_q.size() && j < est_q.size(); j++) begin
            n_cmp++; if (st_q[j].pts !== est_q[j].pts || st_q[j].unp !== est_q[j].unp) begin
                n_bad++; $display("FAIL rnd_stats%0d: got %0d/%0d want %0d/%0d", j, st_q[j].pts, st_q[j].unp, est_q[j].pts, est_q[j].unp); end
        end
    endtask

    task automatic test_midreset();
        clear();
        out_ready = 0; in_valid = 1;
        for (int i = 0; i < 3; i++) begin in_q = 11 + i; tick(); end
        n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_fix !== 32'sd11) begin
            n_bad++; $display("FAIL mr_full: got rdy=%b v=%b fix=%0d want rdy=0 v=1 fix=11", in_ready, out_valid, out_fix); end
        in_valid = 0; rst = 1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mr_flush: got %b want 0", out_valid); end
        rst = 0; out_ready = 1;
        @(posedge clk); #1;
        exp_q.delete(); obs_q.delete(); st_q.delete();
        in_valid = 1; in_q = 7;
        tick();
        in_valid = 0;
        n_cmp++; if (out_valid !== 1'b1 || out_code !== 16'd32775 || out_fix !== 32'sd7) begin
            n_bad++; $display("FAIL mr_first: got v=%b code=%0d fix=%0d want v=1 code=32775 fix=7", out_valid, out_code, out_fix); end
        drain();
        n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL mr_leak: got %0d points want 1", obs_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mapping();
        test_backpressure();
        test_block_stats();
        test_back_to_back();
        test_random();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
